// File: rtl/psum_acc_tree.sv
// psum_acc_tree: pipelined PE-product adder tree with channel accumulation
// and pixel finishing (bias, rounding shift, ReLU, saturation).
module psum_acc_tree #(
  parameter int NUM_IN = 9,
  parameter int IN_W   = 25,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8,
  parameter int CH_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [CH_W-1:0]        num_ch,
  input  logic [ACC_W-1:0]       bias,
  input  logic                   relu_en,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat
);

  localparam int STAGES = $clog2(NUM_IN);
  localparam int TW     = IN_W + STAGES;
  localparam int PW     = ACC_W + 2;

  function automatic int lanes(input int l);
    int n;
    n = NUM_IN;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int off(input int l);
    int s;
    s = 0;
    for (int i = 1; i < l; i++) s += lanes(i);
    return s;
  endfunction

  localparam int TOT = off(STAGES + 1);

  localparam logic signed [PW-1:0] RND =
    PW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [PW-1:0] OMAX =
    {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] OMIN =
    {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [NUM_IN*TW-1:0] src0;
  logic [TOT*TW-1:0]    tree_d, tree_q;
  logic [STAGES:1]      vld_d, vld_q;
  logic [STAGES-1:0]    lv;
  logic [TW-1:0]        tr_a, tr_b;

  logic [ACC_W-1:0]     acc_d, acc_q;
  logic [ACC_W-1:0]     tsum_x;
  logic [CH_W-1:0]      cnt_d, cnt_q;
  logic [CH_W-1:0]      grp_d, grp_q;
  logic [CH_W-1:0]      n_eff;
  logic                 last;
  logic                 done_d, done_q;

  logic signed [PW-1:0] pv, prnd, psh;
  logic                 out_valid_d, out_valid_q;
  logic [OUT_W-1:0]     out_data_d, out_data_q;
  logic                 out_sat_d, out_sat_q;

  // Sign-extend each PE lane to the tree width
  always_comb begin
    src0 = '0;
    for (int k = 0; k < NUM_IN; k++)
      src0[k*TW +: TW] = TW'($signed(in_data[k*IN_W +: IN_W]));
  end

  // Valid of the data feeding each tree level, and the valid pipeline
  always_comb begin
    lv[0] = in_valid;
    for (int l = 1; l < STAGES; l++) lv[l] = vld_q[l];
    for (int l = 1; l <= STAGES; l++) vld_d[l] = lv[l-1] & ~clear;
  end

  // Pairwise add per level; odd lane passes through; bubbles hold data
  always_comb begin
    tree_d = tree_q;
    tr_a   = '0;
    tr_b   = '0;
    for (int l = 1; l <= STAGES; l++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (lv[l-1] && j < lanes(l)) begin
          tr_b = '0;
          if (l == 1) begin
            tr_a = src0[(2*j)*TW +: TW];
            if (2*j+1 < NUM_IN)
              tr_b = src0[(2*j+1)*TW +: TW];
          end else begin
            tr_a = tree_q[(off(l-1)+2*j)*TW +: TW];
            if (2*j+1 < lanes(l-1))
              tr_b = tree_q[(off(l-1)+2*j+1)*TW +: TW];
          end
          tree_d[(off(l)+j)*TW +: TW] = tr_a + tr_b;
        end
      end
    end
  end

  // Channel accumulation; group length latched on the first beat
  always_comb begin
    tsum_x = ACC_W'($signed(tree_q[off(STAGES)*TW +: TW]));
    n_eff  = (num_ch == '0) ? CH_W'(1) : num_ch;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    grp_d  = grp_q;
    done_d = 1'b0;
    last   = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (vld_q[STAGES]) begin
      if (cnt_q == '0) begin
        acc_d = tsum_x;
        grp_d = n_eff;
        last  = (n_eff == CH_W'(1));
      end else begin
        acc_d = acc_q + tsum_x;
        last  = (cnt_q == grp_q - CH_W'(1));
      end
      if (last) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CH_W'(1);
      end
    end
  end

  // Bias, round-half-up shift, ReLU and saturation of a finished group
  always_comb begin
    pv   = PW'($signed(acc_q)) + PW'($signed(bias));
    prnd = pv + RND;
    psh  = prnd >>> SHIFT;
    if (relu_en && psh[PW-1]) psh = '0;
    out_valid_d = done_q & ~clear;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (done_q && !clear) begin
      if (psh > OMAX) begin
        out_data_d = OMAX[OUT_W-1:0];
        out_sat_d  = 1'b1;
      end else if (psh < OMIN) begin
        out_data_d = OMIN[OUT_W-1:0];
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = psh[OUT_W-1:0];
        out_sat_d  = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q      <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      grp_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      tree_q      <= tree_d;
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      grp_q       <= grp_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
